// File: rtl/lisnoc_packet_arb.sv
// Packet-level round-robin arbiter sharing one lisnoc link among N inputs.
// A grant is held from HEAD through LAST (or for a single SINGLE flit).
// On the last flit the next owner is picked in the same cycle, so the link
// sees no bubble between packets when another port is already waiting.

// Per-port select slice: forwards the flit/valid of the granted port and
// returns the downstream ready to that port only.
module lisnoc_packet_arb_lane #(
  parameter int FLIT_WIDTH = 34
) (
  input  logic                  sel,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] sel_flit,
  output logic                  sel_valid,
  output logic                  in_ready
);
  assign sel_flit  = sel ? in_flit : '0;
  assign sel_valid = sel & in_valid;
  assign in_ready  = sel & out_ready;
endmodule

module lisnoc_packet_arb #(
  parameter int N               = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*FLIT_WIDTH-1:0] in_flit,
  input  logic [N-1:0]            in_valid,
  output logic [N-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]   out_flit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            gnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                         state, state_nxt;
  logic [N-1:0]                   gnt_nxt, prev_gnt, prev_gnt_nxt;
  logic [N-1:0][FLIT_WIDTH-1:0]   lane_flit;
  logic [N-1:0]                   lane_valid;
  logic                           locked;
  logic [1:0]                     flit_type;
  logic                           is_last;
  logic [N-1:0]                   rearb_req;

  // Rotating priority: first request at or above the slot after 'prev'.
  function automatic logic [N-1:0] rr(input logic [N-1:0] req, input logic [N-1:0] prev);
    logic [N-1:0] res;
    int           base;
    int           idx;
    res  = '0;
    base = 0;
    for (int i = 0; i < N; i++)
      if (prev[i]) base = i;
    for (int k = 1; k <= N; k++) begin
      idx = (base + k) % N;
      if (req[idx] && res == '0) res[idx] = 1'b1;
    end
    return res;
  endfunction

  assign locked = (state == LOCKED);

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_lane
      lisnoc_packet_arb_lane #(.FLIT_WIDTH(FLIT_WIDTH)) u_lane (
        .sel       (gnt[k] & locked),
        .in_flit   (in_flit[k*FLIT_WIDTH +: FLIT_WIDTH]),
        .in_valid  (in_valid[k]),
        .out_ready (out_ready),
        .sel_flit  (lane_flit[k]),
        .sel_valid (lane_valid[k]),
        .in_ready  (in_ready[k])
      );
    end
  endgenerate

  // OR-combine the lanes; at most one lane is selected, none when idle.
  always_comb begin
    out_flit  = '0;
    out_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      out_flit  = out_flit | lane_flit[i];
      out_valid = out_valid | lane_valid[i];
    end
  end

  // LAST (10) and SINGLE (11) both close the packet.
  assign flit_type = out_flit[FLIT_WIDTH-1 -: 2];
  assign is_last   = (flit_type == 2'b10) || (flit_type == 2'b11);
  assign rearb_req = in_valid & ~gnt;

  // Next-state: grant from idle, or hand over on the last flit's transfer.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    prev_gnt_nxt = prev_gnt;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          gnt_nxt      = rr(in_valid, prev_gnt);
          prev_gnt_nxt = rr(in_valid, prev_gnt);
          state_nxt    = LOCKED;
        end
      end
      LOCKED: begin
        if (out_valid && out_ready && is_last) begin
          if (|rearb_req) begin
            gnt_nxt      = rr(rearb_req, gnt);
            prev_gnt_nxt = rr(rearb_req, gnt);
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and priority pointer; port 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      prev_gnt <= {1'b1, {(N-1){1'b0}}};
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      prev_gnt <= prev_gnt_nxt;
    end
  end

endmodule

// File: tb/tb_lisnoc_packet_arb.sv
// Bench for lisnoc_packet_arb (N=4): per-port packet queues feed the DUT,
// a packet-level owner/priority model predicts every cycle's outputs.
module tb_lisnoc_packet_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FW = DW + 2;

  logic            clk, rst_n;
  logic [N*FW-1:0] in_flit;
  logic [N-1:0]    in_valid, in_ready, gnt;
  logic [FW-1:0]   out_flit;
  logic            out_valid, out_ready;

  lisnoc_packet_arb #(.N(N), .FLIT_DATA_WIDTH(DW), .FLIT_TYPE_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .gnt(gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [FW-1:0] q [N][$];
  logic [N-1:0]  obs_hist[$];
  bit   [N-1:0]  hold;
  int            owner, last_port, stall_pct, rdy_pct;
  int            n_assert, n_fail, seq, cyc, first_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int after);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (after + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int p, input int len);
    logic [1:0] t;
    for (int i = 0; i < len; i++) begin
      t = (len == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b00;
      q[p].push_back({t, 8'(p), 24'(seq)});
      seq++;
    end
  endtask

  task automatic model_reset();
    owner     = -1;
    last_port = N - 1;
    for (int k = 0; k < N; k++) q[k].delete();
  endtask

  // One cycle: drive at negedge, check settled outputs, advance the model.
  task automatic run(input int n);
    logic [N-1:0]  v, r, eg, er;
    logic [FW-1:0] fl [N];
    logic [FW-1:0] ef;
    logic          ev;
    logic [1:0]    t;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        fl[k] = (q[k].size() > 0) ? q[k][0] : '0;
        v[k]  = (q[k].size() > 0) && !hold[k] && (int'($urandom_range(99)) >= stall_pct);
        in_flit[k*FW +: FW] = fl[k];
      end
      in_valid  = v;
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      eg = '0; er = '0; ef = '0; ev = 1'b0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        ev = v[owner];
        ef = fl[owner];
        er = out_ready ? eg : '0;
      end
      chk("gnt", 64'(gnt), 64'(eg));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_flit", 64'(out_flit), 64'(ef));
      chk("in_ready", 64'(in_ready), 64'(er));
      cyc++;
      obs_hist.push_back(gnt);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (owner < 0) begin
        if (|v) begin
          owner     = pick(v, last_port);
          last_port = owner;
        end
      end else if (v[owner] && out_ready) begin
        t = fl[owner][FW-1 -: 2];
        void'(q[owner].pop_front());
        if (t == 2'b10 || t == 2'b11) begin
          r = v;
          r[owner] = 1'b0;
          if (|r) begin
            owner     = pick(r, owner);
            last_port = owner;
          end else begin
            owner = -1;
          end
        end
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      done = (owner < 0);
      for (int k = 0; k < N; k++) if (q[k].size() != 0) done = 1'b0;
      if (!done) run(1);
    end
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed pending expected idle");
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; seq = 0; hold = '0;
    stall_pct = 0; rdy_pct = 100;
    rst_n = 1'b1; in_valid = '0; in_flit = '0; out_ready = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_flit", 64'(out_flit), 64'h0);

    // All four ports streaming SINGLE flits: rotation 0,1,2,3,0...
    for (int k = 0; k < N; k++) begin
      push_pkt(k, 1);
      push_pkt(k, 1);
    end
    @(negedge clk); rst_n = 1'b1;
    cyc = 0; first_valid = -1; obs_hist.delete();
    run(9);
    chk("first_valid_cycle", 64'(first_valid), 64'd2);
    chk("rot_g0", 64'(obs_hist[1]), 64'h1);
    chk("rot_g1", 64'(obs_hist[2]), 64'h2);
    chk("rot_g2", 64'(obs_hist[3]), 64'h4);
    chk("rot_g3", 64'(obs_hist[4]), 64'h8);
    chk("rot_g4", 64'(obs_hist[5]), 64'h1);
    drain();

    // 4-flit packet on port 2; port 0 joins after the HEAD.
    push_pkt(2, 4); push_pkt(0, 1);
    hold = 4'b0001; obs_hist.delete();
    run(2);
    hold = '0;
    run(5);
    chk("pkt_f1", 64'(obs_hist[2]), 64'h4);
    chk("pkt_f3", 64'(obs_hist[4]), 64'h4);
    chk("handover_no_bubble", 64'(obs_hist[5]), 64'h1);
    drain();

    // Source stall mid-packet while others request.
    push_pkt(1, 4); push_pkt(3, 1); push_pkt(0, 2);
    run(3);
    hold = 4'b0010;
    run(3);
    hold = '0;
    drain();

    // Downstream back-pressure with LAST pending.
    push_pkt(1, 2); push_pkt(2, 1);
    run(2);
    rdy_pct = 0;
    run(5);
    rdy_pct = 100;
    drain();

    // Lone requester: idle cycle between back-to-back SINGLEs.
    push_pkt(1, 1); push_pkt(1, 1);
    obs_hist.delete();
    run(4);
    chk("lone_c1", 64'(obs_hist[1]), 64'h2);
    chk("lone_gap", 64'(obs_hist[2]), 64'h0);
    chk("lone_c3", 64'(obs_hist[3]), 64'h2);
    drain();

    // Reset mid-packet, then ports 0 and 3 request.
    push_pkt(1, 4); push_pkt(2, 2);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'h0);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    model_reset();
    in_valid = '0;
    push_pkt(0, 1); push_pkt(3, 1);
    @(negedge clk); rst_n = 1'b1;
    obs_hist.delete();
    run(2);
    chk("after_rst_first_gnt", 64'(obs_hist[1]), 64'h1);
    drain();

    // Random traffic with source stalls and back-pressure.
    stall_pct = 20; rdy_pct = 70;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) < 40) begin
        int p;
        p = int'($urandom_range(N - 1));
        if (q[p].size() < 12) push_pkt(p, int'($urandom_range(1, 4)));
      end
      run(1);
    end
    stall_pct = 0; rdy_pct = 100;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
